// File: rtl/timer_pkg.sv
// Shared register map and CTRL layout for the multi-channel timer.
package timer_pkg;

  localparam logic [1:0] ADDR_COUNT   = 2'd0;
  localparam logic [1:0] ADDR_RELOAD  = 2'd1;
  localparam logic [1:0] ADDR_COMPARE = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_DOWN     = 2;
  localparam int CTRL_IRQ_EN   = 3;
  localparam int CTRL_W        = 4;

  typedef struct packed {
    logic irq_en;
    logic down;
    logic periodic;
    logic enable;
  } ctrl_t;

  function automatic ctrl_t ctrl_unpack(input logic [CTRL_W-1:0] bits);
    ctrl_t c;
    c.enable   = bits[CTRL_EN];
    c.periodic = bits[CTRL_PERIODIC];
    c.down     = bits[CTRL_DOWN];
    c.irq_en   = bits[CTRL_IRQ_EN];
    return c;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: COUNT/RELOAD/COMPARE/CTRL registers, terminal-count and compare flags.
// Register writes land on the next clk edge; a COUNT write beats a same-cycle tick update.
module timer_channel
  import timer_pkg::*;
#(
  parameter int COUNTER_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    wr_sel,
  input  logic [1:0]              wr_addr,
  input  logic [COUNTER_SIZE-1:0] wr_data,
  input  logic                    irq_clr,
  output logic [COUNTER_SIZE-1:0] count,
  output logic                    tc_flag,
  output logic                    cmp_flag,
  output logic                    irq_req
);

  logic [COUNTER_SIZE-1:0] count_q, count_d;
  logic [COUNTER_SIZE-1:0] reload_q, reload_d;
  logic [COUNTER_SIZE-1:0] compare_q, compare_d;
  ctrl_t                   ctrl_q, ctrl_d;
  logic                    tc_q, tc_d;
  logic                    cmp_q, cmp_d;
  logic                    upd_q, upd_d;

  logic tc_set;
  logic at_term;
  logic ctrl_stop;
  logic step;

  always_comb begin
    count_d   = count_q;
    reload_d  = reload_q;
    compare_d = compare_q;
    ctrl_d    = ctrl_q;
    upd_d     = 1'b0;
    tc_set    = 1'b0;

    // Up mode terminates at or above RELOAD so a COUNT written past RELOAD never wraps.
    at_term   = ctrl_q.down ? (count_q == '0) : (count_q >= reload_q);
    ctrl_stop = wr_sel && (wr_addr == ADDR_CTRL) && !wr_data[CTRL_EN];
    step      = tick && ctrl_q.enable && !ctrl_stop;

    if (step) begin
      if (at_term) begin
        tc_set = 1'b1;
        if (ctrl_q.periodic) begin
          count_d = ctrl_q.down ? reload_q : '0;
          upd_d   = 1'b1;
        end else begin
          ctrl_d.enable = 1'b0;
        end
      end else begin
        count_d = ctrl_q.down ? (count_q - COUNTER_SIZE'(1)) : (count_q + COUNTER_SIZE'(1));
        upd_d   = 1'b1;
      end
    end

    if (wr_sel) begin
      unique case (wr_addr)
        ADDR_COUNT: begin
          count_d = wr_data;
          upd_d   = 1'b1;
        end
        ADDR_RELOAD:  reload_d  = wr_data;
        ADDR_COMPARE: compare_d = wr_data;
        default:      ctrl_d    = ctrl_unpack(wr_data[CTRL_W-1:0]);
      endcase
    end

    // A set on the same edge as a clear wins.
    tc_d  = (tc_q & ~irq_clr) | tc_set;
    cmp_d = (cmp_q & ~irq_clr) | (upd_q && (count_q == compare_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      reload_q  <= '0;
      compare_q <= '0;
      ctrl_q    <= '0;
      tc_q      <= 1'b0;
      cmp_q     <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      reload_q  <= reload_d;
      compare_q <= compare_d;
      ctrl_q    <= ctrl_d;
      tc_q      <= tc_d;
      cmp_q     <= cmp_d;
      upd_q     <= upd_d;
    end
  end

  assign count    = count_q;
  assign tc_flag  = tc_q;
  assign cmp_flag = cmp_q;
  assign irq_req  = (tc_q | cmp_q) & ctrl_q.irq_en;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel timer: free-running shared prescaler, register write decode, NUM_CH channels.
// irq is combinational from registered flags; writes take effect on the next clk edge.
module timer_multi
  import timer_pkg::*;
#(
  parameter int  COUNTER_SIZE  = 16,
  parameter int  NUM_CH        = 4,
  parameter int  PRESCALE_SIZE = 8,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PRESCALE_SIZE-1:0]       prescale,
  input  logic                           wr_en,
  input  logic [CH_W-1:0]                wr_ch,
  input  logic [1:0]                     wr_addr,
  input  logic [COUNTER_SIZE-1:0]        wr_data,
  input  logic [NUM_CH-1:0]              irq_clr,
  output logic [NUM_CH*COUNTER_SIZE-1:0] count,
  output logic [NUM_CH-1:0]              tc_flag,
  output logic [NUM_CH-1:0]              cmp_flag,
  output logic                           irq
);

  logic [PRESCALE_SIZE-1:0] presc_q, presc_d;
  logic                     tick;
  logic [NUM_CH-1:0]        irq_req;

  // >= rather than == so lowering prescale mid-run cannot strand the counter above it.
  always_comb begin
    tick    = (presc_q >= prescale);
    presc_d = tick ? '0 : (presc_q + PRESCALE_SIZE'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Only channel indices that exist can match, so out-of-range writes fall on the floor.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = wr_en && (int'(wr_ch) == i);

    timer_channel #(
      .COUNTER_SIZE(COUNTER_SIZE)
    ) u_channel (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .wr_sel  (wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .irq_clr (irq_clr[i]),
      .count   (count[i*COUNTER_SIZE +: COUNTER_SIZE]),
      .tc_flag (tc_flag[i]),
      .cmp_flag(cmp_flag[i]),
      .irq_req (irq_req[i])
    );
  end

  assign irq = |irq_req;

endmodule

// File: tb/tb_timer_multi.sv
// Directed self-checking bench for timer_multi (4 channels, 16-bit counters, 8-bit prescaler).
module tb_timer_multi;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  prescale;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  irq_clr;
  logic [63:0] count;
  logic [3:0]  tc_flag;
  logic [3:0]  cmp_flag;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  timer_multi #(.COUNTER_SIZE(16), .NUM_CH(4), .PRESCALE_SIZE(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .prescale(prescale),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .irq_clr (irq_clr),
    .count   (count),
    .tc_flag (tc_flag),
    .cmp_flag(cmp_flag),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cnt(input int ch);
    return count[ch*16 +: 16];
  endfunction

  // Called at a negedge; the write lands on the following posedge, returns at the next negedge.
  task automatic do_write(input int ch, input logic [1:0] addr, input logic [15:0] data);
    wr_en   = 1'b1;
    wr_ch   = ch[1:0];
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic test_reset;
    prescale = 8'd3;
    wr_en    = 1'b0;
    wr_ch    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    irq_clr  = '0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (count !== 64'd0) begin n_bad++; $display("FAIL reset_count got=%h exp=0", count); end
    n_cmp++;
    if ({tc_flag, cmp_flag, irq} !== 9'd0) begin
      n_bad++; $display("FAIL reset_flags got=%b exp=0", {tc_flag, cmp_flag, irq});
    end
    rst = 1'b0;
  endtask

  // Starts at the release negedge (N0); enable lands on the prescaler wrap edge at E4.
  task automatic test_periodic_up;
    logic [15:0] exp;
    do_write(0, ADDR_RELOAD, 16'd5);
    repeat (2) @(negedge clk);
    do_write(0, ADDR_CTRL, 16'h0003);
    for (int k = 4; k <= 28; k++) begin
      exp = (k == 28) ? 16'd0 : 16'((k - 4) / 4);
      n_cmp++;
      if (cnt(0) !== exp) begin n_bad++; $display("FAIL periodic_count n=%0d got=%0d exp=%0d", k, cnt(0), exp); end
      n_cmp++;
      if (tc_flag[0] !== (k == 28)) begin
        n_bad++; $display("FAIL periodic_tc n=%0d got=%b exp=%b", k, tc_flag[0], (k == 28));
      end
      if (k < 28) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (cnt(0) !== 16'd1) begin n_bad++; $display("FAIL periodic_rerun got=%0d exp=1", cnt(0)); end
    do_write(0, ADDR_CTRL, 16'h0000);
    irq_clr = 4'b0001;
    @(negedge clk);
    irq_clr = 4'b0000;
    prescale = 8'd0;
    @(negedge clk);
  endtask

  // Also covers irq_clr coinciding with the terminal-count set.
  task automatic test_oneshot_down;
    do_write(1, ADDR_COUNT, 16'd3);
    do_write(1, ADDR_CTRL, 16'h0005);
    n_cmp++;
    if (cnt(1) !== 16'd3) begin n_bad++; $display("FAIL oneshot_start got=%0d exp=3", cnt(1)); end
    for (int v = 2; v >= 0; v--) begin
      @(negedge clk);
      n_cmp++;
      if (cnt(1) !== 16'(v)) begin n_bad++; $display("FAIL oneshot_count got=%0d exp=%0d", cnt(1), v); end
    end
    n_cmp++;
    if (tc_flag[1] !== 1'b0) begin n_bad++; $display("FAIL oneshot_tc_early got=%b exp=0", tc_flag[1]); end
    irq_clr = 4'b0010;
    @(negedge clk);
    irq_clr = 4'b0000;
    n_cmp++;
    if (tc_flag[1] !== 1'b1) begin n_bad++; $display("FAIL set_beats_clear got=%b exp=1", tc_flag[1]); end
    n_cmp++;
    if (cnt(1) !== 16'd0) begin n_bad++; $display("FAIL oneshot_hold got=%0d exp=0", cnt(1)); end
    irq_clr = 4'b0010;
    @(negedge clk);
    irq_clr = 4'b0000;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tc_flag[1] !== 1'b0) begin n_bad++; $display("FAIL oneshot_disabled got=%b exp=0", tc_flag[1]); end
    n_cmp++;
    if (cnt(1) !== 16'd0) begin n_bad++; $display("FAIL oneshot_hold_late got=%0d exp=0", cnt(1)); end
  endtask

  task automatic test_compare_irq;
    logic [15:0] frz;
    do_write(2, ADDR_COMPARE, 16'd7);
    do_write(2, ADDR_RELOAD, 16'd20);
    do_write(2, ADDR_CTRL, 16'h0009);
    n_cmp++;
    if (cnt(2) !== 16'd0) begin n_bad++; $display("FAIL cmp_start got=%0d exp=0", cnt(2)); end
    repeat (7) @(negedge clk);
    n_cmp++;
    if (cnt(2) !== 16'd7) begin n_bad++; $display("FAIL cmp_count got=%0d exp=7", cnt(2)); end
    n_cmp++;
    if ({cmp_flag[2], irq} !== 2'b00) begin n_bad++; $display("FAIL cmp_early got=%b exp=00", {cmp_flag[2], irq}); end
    @(negedge clk);
    n_cmp++;
    if ({cmp_flag[2], irq} !== 2'b11) begin n_bad++; $display("FAIL cmp_rise got=%b exp=11", {cmp_flag[2], irq}); end
    irq_clr = 4'b0100;
    @(negedge clk);
    irq_clr = 4'b0000;
    n_cmp++;
    if ({cmp_flag[2], irq} !== 2'b00) begin n_bad++; $display("FAIL cmp_clear got=%b exp=00", {cmp_flag[2], irq}); end
    n_cmp++;
    if (cnt(2) !== 16'd9) begin n_bad++; $display("FAIL cmp_run got=%0d exp=9", cnt(2)); end
    frz = cnt(2);
    do_write(2, ADDR_CTRL, 16'h0000);
    n_cmp++;
    if (cnt(2) !== frz) begin n_bad++; $display("FAIL freeze got=%0d exp=%0d", cnt(2), frz); end
    @(negedge clk);
    n_cmp++;
    if (cnt(2) !== frz) begin n_bad++; $display("FAIL freeze_hold got=%0d exp=%0d", cnt(2), frz); end
  endtask

  task automatic test_count_override;
    logic [15:0] c0;
    do_write(0, ADDR_COUNT, 16'd0);
    do_write(0, ADDR_RELOAD, 16'hFFFF);
    do_write(3, ADDR_RELOAD, 16'hFFFF);
    do_write(3, ADDR_COMPARE, 16'h0100);
    do_write(0, ADDR_CTRL, 16'h0003);
    do_write(3, ADDR_CTRL, 16'h0009);
    c0 = cnt(0);
    do_write(3, ADDR_COUNT, 16'h0100);
    n_cmp++;
    if (cnt(3) !== 16'h0100) begin n_bad++; $display("FAIL override_ch3 got=%h exp=0100", cnt(3)); end
    n_cmp++;
    if (cnt(0) !== c0 + 16'd1) begin n_bad++; $display("FAIL override_ch0 got=%0d exp=%0d", cnt(0), c0 + 16'd1); end
    @(negedge clk);
    n_cmp++;
    if (cnt(3) !== 16'h0101) begin n_bad++; $display("FAIL override_next got=%h exp=0101", cnt(3)); end
    n_cmp++;
    if ({cmp_flag[3], irq} !== 2'b11) begin n_bad++; $display("FAIL write_cmp got=%b exp=11", {cmp_flag[3], irq}); end
  endtask

  task automatic test_reset_midcount;
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (count !== 64'd0) begin n_bad++; $display("FAIL async_count got=%h exp=0", count); end
    n_cmp++;
    if ({tc_flag, cmp_flag, irq} !== 9'd0) begin
      n_bad++; $display("FAIL async_flags got=%b exp=0", {tc_flag, cmp_flag, irq});
    end
    prescale = 8'd3;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_write(0, ADDR_CTRL, 16'h0001);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (tc_flag[0] !== 1'b0) begin n_bad++; $display("FAIL first_tick_early got=%b exp=0", tc_flag[0]); end
    @(negedge clk);
    n_cmp++;
    if (tc_flag[0] !== 1'b1) begin n_bad++; $display("FAIL first_tick got=%b exp=1", tc_flag[0]); end
    n_cmp++;
    if (cnt(0) !== 16'd0) begin n_bad++; $display("FAIL first_tick_count got=%0d exp=0", cnt(0)); end
  endtask

  initial begin
    test_reset();
    test_periodic_up();
    test_oneshot_down();
    test_compare_irq();
    test_count_override();
    test_reset_midcount();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
